// File: rtl/exe_unit_driver.sv
// exe_unit_driver: issues one ALU command to an exe unit, waits its latency, returns result/status.
module exe_unit_driver #(
  parameter int ARG_BYTES   = 4,
  parameter int EXE_LATENCY = 1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rsn,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [1:0]           i_cmd_oper,
  input  logic [ARG_BYTES-1:0] i_cmd_argA,
  input  logic [ARG_BYTES-1:0] i_cmd_argB,
  output logic [1:0]           o_exe_oper,
  output logic [ARG_BYTES-1:0] o_exe_argA,
  output logic [ARG_BYTES-1:0] o_exe_argB,
  input  logic [ARG_BYTES-1:0] i_exe_result,
  input  logic [3:0]           i_exe_status,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [ARG_BYTES-1:0] o_rsp_result,
  output logic [3:0]           o_rsp_status,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int CW = EXE_LATENCY > 1 ? $clog2(EXE_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(EXE_LATENCY - 1);
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [1:0]           oper_q;
  logic [ARG_BYTES-1:0] arg_a_q, arg_b_q, res_q;
  logic [3:0]           st_q;
  logic [ERR_CNT_W-1:0] err_q;
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      oper_q  <= '0;
      arg_a_q <= '0;
      arg_b_q <= '0;
      res_q   <= '0;
      st_q    <= '0;
      err_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_cmd_valid) begin
          oper_q  <= i_cmd_oper;
          arg_a_q <= i_cmd_argA;
          arg_b_q <= i_cmd_argB;
          cnt_q   <= CNT_INIT;
          state_q <= WAIT;
        end
        WAIT: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        else begin
          res_q   <= i_exe_result;
          st_q    <= i_exe_status;
          if (i_exe_status[3] && err_q != '1) err_q <= err_q + 1'b1;
          state_q <= RESP;
        end
        RESP: if (i_rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_cmd_ready  = state_q == IDLE;
  assign o_rsp_valid  = state_q == RESP;
  assign o_exe_oper   = oper_q;
  assign o_exe_argA   = arg_a_q;
  assign o_exe_argB   = arg_b_q;
  assign o_rsp_result = res_q;
  assign o_rsp_status = st_q;
  assign o_err_cnt    = err_q;
endmodule

// File: tb/tb_exe_unit_driver.sv
// tb_exe_unit_driver: directed checks of two driver configurations (latency 1 / 2-bit counter, latency 3).
module tb_exe_unit_driver;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;

  logic       v1, rdy1, rv1, rr1;
  logic [1:0] op1, eop1;
  logic [3:0] a1, b1, ea1, eb1, xr1, xs1, rres1, rst1;
  logic [1:0] err1;
  logic       v3, rdy3, rv3, rr3;
  logic [1:0] op3, eop3;
  logic [3:0] a3, b3, ea3, eb3, xr3, xs3, rres3, rst3;
  logic [7:0] err3;

  assign xr1 = eop1 == 2'd3 ? 4'h0 : ea1 + eb1;
  assign xs1 = eop1 == 2'd3 ? 4'b1000 : 4'h0;

  exe_unit_driver #(.ARG_BYTES(4), .EXE_LATENCY(1), .ERR_CNT_W(2)) u1 (
    .i_clk(clk), .i_rsn(rst_n), .i_cmd_valid(v1), .o_cmd_ready(rdy1),
    .i_cmd_oper(op1), .i_cmd_argA(a1), .i_cmd_argB(b1),
    .o_exe_oper(eop1), .o_exe_argA(ea1), .o_exe_argB(eb1),
    .i_exe_result(xr1), .i_exe_status(xs1), .o_rsp_valid(rv1), .i_rsp_ready(rr1),
    .o_rsp_result(rres1), .o_rsp_status(rst1), .o_err_cnt(err1));

  exe_unit_driver #(.ARG_BYTES(4), .EXE_LATENCY(3), .ERR_CNT_W(8)) u3 (
    .i_clk(clk), .i_rsn(rst_n), .i_cmd_valid(v3), .o_cmd_ready(rdy3),
    .i_cmd_oper(op3), .i_cmd_argA(a3), .i_cmd_argB(b3),
    .o_exe_oper(eop3), .o_exe_argA(ea3), .o_exe_argB(eb3),
    .i_exe_result(xr3), .i_exe_status(xs3), .o_rsp_valid(rv3), .i_rsp_ready(rr3),
    .o_rsp_result(rres3), .o_rsp_status(rst3), .o_err_cnt(err3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run1(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] er, input logic [3:0] es, input logic [1:0] ee);
    v1 = 1'b1; op1 = op; a1 = a; b1 = b; rr1 = 1'b1;
    tick();
    v1 = 1'b0;
    chk("run_exe_oper", eop1, op);
    chk("run_rv_wait", rv1, 0);
    tick();
    chk("run_rv", rv1, 1);
    chk("run_res", rres1, er);
    chk("run_st", rst1, es);
    chk("run_err", err1, ee);
    tick();
    chk("run_idle_rdy", rdy1, 1);
    chk("run_idle_rv", rv1, 0);
  endtask

  initial begin
    logic [3:0] exp_q [4];
    logic [1:0] cop [4];
    logic [3:0] ca [4], cb [4];
    int idx, nresp, last;
    logic prev_rdy;
    v1 = 1'b1; op1 = 2'd1; a1 = 4'h5; b1 = 4'h6; rr1 = 1'b0;
    v3 = 1'b0; op3 = 2'd0; a3 = 4'h0; b3 = 4'h0; rr3 = 1'b0; xr3 = 4'h0; xs3 = 4'h0;
    tick();
    tick();
    // reset state, with a command held valid during reset
    chk("rst_rdy1", rdy1, 1);
    chk("rst_rv1", rv1, 0);
    chk("rst_ea1", ea1, 0);
    chk("rst_eop1", eop1, 0);
    chk("rst_res1", rres1, 0);
    chk("rst_err1", err1, 0);
    chk("rst_rdy3", rdy3, 1);
    v1 = 1'b0;
    rst_n = 1'b1;
    tick();

    // test 1: 3+4
    v1 = 1'b1; op1 = 2'd0; a1 = 4'h3; b1 = 4'h4; rr1 = 1'b0;
    chk("t1_pre_ea", ea1, 0);
    tick();
    v1 = 1'b0;
    chk("t1_ea", ea1, 4'h3);
    chk("t1_eb", eb1, 4'h4);
    chk("t1_rdy", rdy1, 0);
    chk("t1_rv_early", rv1, 0);
    tick();
    chk("t1_rv", rv1, 1);
    chk("t1_res", rres1, 4'h7);
    chk("t1_st", rst1, 4'h0);
    chk("t1_err", err1, 0);

    // test 3: stall in RESP with a competing command
    v1 = 1'b1; op1 = 2'd3; a1 = 4'h9; b1 = 4'h1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_rv", rv1, 1);
      chk("t3_res", rres1, 4'h7);
      chk("t3_st", rst1, 4'h0);
      chk("t3_rdy", rdy1, 0);
      chk("t3_ea_hold", ea1, 4'h3);
    end
    v1 = 1'b0; rr1 = 1'b1;
    tick();
    chk("t3_idle_rdy", rdy1, 1);
    chk("t3_idle_rv", rv1, 0);
    chk("t3_ea_idle", ea1, 4'h3);
    rr1 = 1'b0;

    // test 2: error results, counter saturates at 3
    run1(2'd3, 4'h1, 4'h2, 4'h0, 4'b1000, 2'd1);
    run1(2'd3, 4'h2, 4'h2, 4'h0, 4'b1000, 2'd2);
    run1(2'd3, 4'h3, 4'h2, 4'h0, 4'b1000, 2'd3);
    run1(2'd3, 4'h4, 4'h2, 4'h0, 4'b1000, 2'd3);
    run1(2'd3, 4'h5, 4'h2, 4'h0, 4'b1000, 2'd3);

    // test 6: back-to-back commands with valid held high
    cop = '{2'd0, 2'd0, 2'd0, 2'd0};
    ca = '{4'h1, 4'h2, 4'h6, 4'hF};
    cb = '{4'h1, 4'h5, 4'h6, 4'h2};
    exp_q = '{4'h2, 4'h7, 4'hC, 4'h1};
    idx = 0; nresp = 0; last = 0;
    rr1 = 1'b1; v1 = 1'b1; op1 = cop[0]; a1 = ca[0]; b1 = cb[0];
    for (int cyc = 1; cyc <= 16; cyc++) begin
      prev_rdy = rdy1;
      tick();
      if (prev_rdy && v1) begin
        idx++;
        if (idx < 4) begin
          op1 = cop[idx]; a1 = ca[idx]; b1 = cb[idx];
        end else v1 = 1'b0;
      end
      if (rv1) begin
        if (nresp < 4) chk("t6_res", rres1, exp_q[nresp]);
        if (nresp > 0) chk("t6_spacing", cyc - last, 3);
        last = cyc;
        nresp++;
      end
    end
    chk("t6_count", nresp, 4);
    chk("t6_err_hold", err1, 2'd3);
    rr1 = 1'b0;

    // test 4: latency 3, model output differs at edges 2, 3 and 4
    v3 = 1'b1; op3 = 2'd2; a3 = 4'h1; b3 = 4'h4; xr3 = 4'hA; xs3 = 4'h0;
    tick();
    v3 = 1'b0;
    chk("t4_eop", eop3, 2'd2);
    chk("t4_ea", ea3, 4'h1);
    tick();
    chk("t4_rv_e1", rv3, 0);
    tick();
    chk("t4_rv_e2", rv3, 0);
    xr3 = 4'h5; xs3 = 4'b1000;
    tick();
    chk("t4_rv_e3", rv3, 1);
    chk("t4_res", rres3, 4'h5);
    chk("t4_st", rst3, 4'b1000);
    chk("t4_err", err3, 8'd1);
    xr3 = 4'hC; xs3 = 4'h0;
    rr3 = 1'b1;
    tick();
    chk("t4_idle", rdy3, 1);
    rr3 = 1'b0;

    // test 5a: reset while in WAIT
    v3 = 1'b1; op3 = 2'd1; a3 = 4'h2; b3 = 4'h2;
    tick();
    v3 = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5w_eop", eop3, 0);
    chk("t5w_ea", ea3, 0);
    chk("t5w_rv", rv3, 0);
    chk("t5w_rdy", rdy3, 1);
    chk("t5w_err3", err3, 0);
    chk("t5w_res", rres3, 0);
    chk("t5w_st", rst3, 0);
    chk("t5w_err1", err1, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // test 5b: reset while stalled in RESP
    v3 = 1'b1; op3 = 2'd0; a3 = 4'h3; b3 = 4'h3; xr3 = 4'h6; xs3 = 4'b1000;
    tick();
    v3 = 1'b0;
    tick();
    tick();
    tick();
    chk("t5r_rv", rv3, 1);
    chk("t5r_err_pre", err3, 8'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5r_rv0", rv3, 0);
    chk("t5r_rdy", rdy3, 1);
    chk("t5r_res", rres3, 0);
    chk("t5r_st", rst3, 0);
    chk("t5r_ea", ea3, 0);
    chk("t5r_err", err3, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // first commands after reset complete normally
    run1(2'd0, 4'h2, 4'h3, 4'h5, 4'h0, 2'd0);
    v3 = 1'b1; op3 = 2'd0; a3 = 4'h4; b3 = 4'h4; xr3 = 4'h8; xs3 = 4'h0;
    tick();
    v3 = 1'b0;
    tick();
    tick();
    tick();
    chk("t5n_rv", rv3, 1);
    chk("t5n_res", rres3, 4'h8);
    chk("t5n_err", err3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
